// File: rtl/prbg_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// default widths used by seq_detector and sat_counter.
package prbg_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating match counter with a sticky flag that sets when an increment
// arrives while the count is already at its maximum.
module sat_counter
    import prbg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc) begin
            if (count_q == {CNT_W{1'b1}}) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector.sv
// Serial sequence detector: shifts qualified bits into a PAT_W-bit window and
// pulses match when a full window equals the pattern latched at start.
module seq_detector
    import prbg_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             cnt_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    det_state_e        state_q, state_d;
    logic [PAT_W-1:0]  window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;
    logic              match_q, match_d;
    logic              busy_q, busy_d;
    logic              cnt_inc, cnt_clr;
    logic [PAT_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill_nxt;

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        match_d  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        win_nxt  = {window_q[PAT_W-2:0], bit_in};
        fill_nxt = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

        // stop outranks start; a start/stop cycle never consumes a bit
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            pat_d    = pattern;
            ovl_d    = overlap;
            window_d = '0;
            fill_d   = '0;
            cnt_clr  = 1'b1;
            state_d  = ST_FILL;
        end else if (state_q != ST_IDLE && bit_vld) begin
            window_d = win_nxt;
            fill_d   = fill_nxt;
            state_d  = (fill_nxt == FILL_FULL) ? ST_RUN : ST_FILL;
            if (fill_nxt == FILL_FULL && win_nxt == pat_q) begin
                match_d = 1'b1;
                cnt_inc = 1'b1;
                // non-overlapping mode needs PAT_W fresh bits for the next hit
                if (!ovl_q) begin
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= ST_IDLE;
            window_q <= '0;
            fill_q   <= '0;
            pat_q    <= '0;
            ovl_q    <= 1'b0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            ovl_q    <= ovl_d;
            match_q  <= match_d;
            busy_q   <= busy_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .res   (res),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

    assign match = match_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: a bit-history reference model queues the
// expected match pulses, a negedge monitor pops and compares them.
module tb_seq_detector;

    localparam int PW   = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic          overlap = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_vld = 1'b0;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          cnt_sat;

    seq_detector #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .stop      (stop),
        .pattern   (pattern),
        .overlap   (overlap),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .match     (match),
        .match_cnt (match_cnt),
        .busy      (busy),
        .cnt_sat   (cnt_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int cnt;
        bit sat;
    } exp_t;

    exp_t    exp_q[$];
    int      checks = 0;
    int      failures = 0;

    // reference model: raw history of consumed bits since the last (re)arm
    bit      m_active = 1'b0;
    bit      m_ovl = 1'b0;
    bit [PW-1:0] m_pat = '0;
    bit      hist[$];
    int      m_hits = 0;

    function automatic int exp_cnt();
        return (m_hits > MAXC) ? MAXC : m_hits;
    endfunction

    task automatic model_step(input bit st, input bit sp, input bit v, input bit b);
        bit hit;
        if (sp) begin
            m_active = 1'b0;
        end else if (st) begin
            m_active = 1'b1;
            m_pat    = pattern;
            m_ovl    = overlap;
            hist.delete();
            m_hits   = 0;
        end else if (m_active && v) begin
            hist.push_back(b);
            if (hist.size() > PW) void'(hist.pop_front());
            if (hist.size() == PW) begin
                hit = 1'b1;
                for (int i = 0; i < PW; i++)
                    if (hist[i] != m_pat[PW-1-i]) hit = 1'b0;
                if (hit) begin
                    m_hits++;
                    exp_q.push_back('{cyc + 1, exp_cnt(), m_hits > MAXC});
                    if (!m_ovl) hist.delete();
                end
            end
        end
    endtask

    task automatic drive(input bit st, input bit sp, input bit v, input bit b);
        start   = st;
        stop    = sp;
        bit_vld = v;
        bit_in  = b;
        model_step(st, sp, v, b);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_end(input string name);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk({name, "_cnt"}, 32'(match_cnt), 32'(exp_cnt()));
        chk({name, "_sat"}, 32'(cnt_sat), 32'(m_hits > MAXC));
        chk({name, "_busy"}, 32'(busy), 32'(m_active));
        chk({name, "_pending"}, 32'(exp_q.size()), 0);
    endtask

    task automatic arm(input bit [PW-1:0] p, input bit o);
        pattern = p;
        overlap = o;
        drive(1, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_match actual=none required=pulse_at_cycle_%0d", e.due);
        end
        if (match === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_match actual=pulse_at_cycle_%0d required=none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.due != cyc || match_cnt != CW'(e.cnt) || cnt_sat != e.sat) begin
                    failures++;
                    $display("FAIL match_pulse actual=cyc%0d/cnt%0d/sat%0d required=cyc%0d/cnt%0d/sat%0d",
                             cyc, match_cnt, cnt_sat, e.due, e.cnt, e.sat);
                end
            end
        end
    end

    initial begin
        bit [6:0] stream;
        stream = 7'b1011011;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_match", 32'(match), 0);
        chk("reset_cnt", 32'(match_cnt), 0);
        chk("reset_busy_sat", 32'({busy, cnt_sat}), 0);
        res = 1'b0;
        drive(0, 0, 0, 0);

        // overlapping: hits after bits 4 and 7
        arm(4'b1011, 1'b1);
        chk("start_busy", 32'(busy), 1);
        for (int i = 6; i >= 0; i--) drive(0, 0, 1, stream[i]);
        check_end("ovl_stream");

        // non-overlapping: one hit, back in FILL
        arm(4'b1011, 1'b0);
        for (int i = 6; i >= 0; i--) drive(0, 0, 1, stream[i]);
        check_end("novl_stream");

        // overlapping with invalid gaps between bits
        arm(4'b1011, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            drive(0, 0, 1, stream[i]);
            repeat ($urandom_range(0, 3)) drive(0, 0, 0, 1'($urandom));
        end
        check_end("gap_stream");

        // saturation with CNT_W=2
        arm(4'b1111, 1'b1);
        repeat (7) drive(0, 0, 1, 1);
        check_end("sat_stream");

        // start+stop together in RUN: stop wins, counters hold
        drive(1, 1, 0, 0);
        check_end("start_stop");
        chk("start_stop_cnt_held", 32'(match_cnt), MAXC);
        arm(4'b0110, 1'b0);
        chk("restart_clear", 32'({match_cnt, cnt_sat, busy}), 32'({2'b00, 1'b0, 1'b1}));

        // stop, then stop and bits while IDLE are ignored
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        repeat (6) drive(0, 0, 1, 1'($urandom));
        check_end("idle_ignore");

        // asynchronous reset mid-RUN with a matching bit pending
        arm(4'b1011, 1'b1);
        drive(0, 0, 1, 1); drive(0, 0, 1, 0); drive(0, 0, 1, 1); drive(0, 0, 1, 1);
        drive(0, 0, 1, 0); drive(0, 0, 1, 1);
        bit_vld = 1'b1;
        bit_in  = 1'b1;
        #2;
        res = 1'b1;
        #1;
        chk("async_reset_cnt", 32'(match_cnt), 0);
        chk("async_reset_busy_match", 32'({busy, match, cnt_sat}), 0);
        m_active = 1'b0;
        m_hits   = 0;
        hist.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        res = 1'b0;
        repeat (3) drive(0, 0, 1, 1);
        check_end("post_reset");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pattern = PW'($urandom);
            overlap = 1'($urandom);
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 69) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom));
            if (n % 300 == 299) check_end("random");
        end
        check_end("random_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
